// File: rtl/fb_write_scheduler_if.sv
// rtl/fb_write_scheduler_if.sv - request, clear and framebuffer write-port signal bundle
interface fb_write_scheduler_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              clr_start;
    logic [DATA_W-1:0] clr_data;
    logic              clr_busy;
    logic              clr_done;
    logic [ADDR_W-1:0] fb_waddr;
    logic [DATA_W-1:0] fb_din;
    logic              fb_we;
    logic              fb_ce;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output clr_start, clr_data,
        input  req0_ready, req1_ready, clr_busy, clr_done,
        input  fb_waddr, fb_din, fb_we, fb_ce
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  clr_start, clr_data,
        output req0_ready, req1_ready, clr_busy, clr_done,
        output fb_waddr, fb_din, fb_we, fb_ce
    );
endinterface

// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - round-robin framebuffer write-port arbiter with clear engine
module fb_write_scheduler #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    fb_write_scheduler_if.slave  bus
);
    typedef enum logic {ARB, CLEAR} state_t;

    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t            state_q, state_d;
    logic              rr_ptr;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] clr_color;
    logic              rdy0, rdy1;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] din_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;

    // Readies depend only on valids, state, clr_start and rr_ptr, never on each other.
    always_comb begin
        rdy0    = 1'b0;
        rdy1    = 1'b0;
        state_d = state_q;
        case (state_q)
            ARB: begin
                if (bus.clr_start) begin
                    state_d = CLEAR;
                end else if (bus.req0_valid && (!bus.req1_valid || !rr_ptr)) begin
                    rdy0 = 1'b1;
                end else if (bus.req1_valid) begin
                    rdy1 = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt == LAST) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ARB;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= 1'b0;
            cnt       <= '0;
            clr_color <= '0;
            waddr_q   <= '0;
            din_q     <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ARB: begin
                    if (rdy0) begin
                        we_q    <= 1'b1;
                        waddr_q <= bus.req0_addr;
                        din_q   <= bus.req0_data;
                        rr_ptr  <= 1'b1;
                    end else if (rdy1) begin
                        we_q    <= 1'b1;
                        waddr_q <= bus.req1_addr;
                        din_q   <= bus.req1_data;
                        rr_ptr  <= 1'b0;
                    end
                    if (bus.clr_start) begin
                        clr_color <= bus.clr_data;
                        cnt       <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                CLEAR: begin
                    we_q    <= 1'b1;
                    waddr_q <= cnt[ADDR_W-1:0];
                    din_q   <= clr_color;
                    cnt     <= cnt + 1'b1;
                    // Done lands on the same edge as the final address write.
                    if (cnt == LAST) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.fb_waddr   = waddr_q;
    assign bus.fb_din     = din_q;
    assign bus.fb_we      = we_q;
    assign bus.fb_ce      = we_q;
    assign bus.clr_busy   = busy_q;
    assign bus.clr_done   = done_q;
endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb/tb_fb_write_scheduler.sv - directed self-checking bench for fb_write_scheduler
module tb_fb_write_scheduler;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   bad;

    always #5 clk = ~clk;

    fb_write_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_write_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.clr_start  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        bus.req0_addr = '0;
        bus.req0_data = '0;
        bus.req1_addr = '0;
        bus.req1_data = '0;
        bus.clr_data  = '0;
        do_reset();

        chk("rst_we",    bus.fb_we,    0);
        chk("rst_ce",    bus.fb_ce,    0);
        chk("rst_waddr", bus.fb_waddr, 0);
        chk("rst_din",   bus.fb_din,   0);
        chk("rst_busy",  bus.clr_busy, 0);
        chk("rst_done",  bus.clr_done, 0);

        // 1: single port-0 write
        bus.req0_valid = 1'b1; bus.req0_addr = 12'h041; bus.req0_data = 4'h5;
        #1;
        chk("t1_r0", bus.req0_ready, 1);
        chk("t1_r1", bus.req1_ready, 0);
        cyc();
        bus.req0_valid = 1'b0;
        chk("t1_we",    bus.fb_we,    1);
        chk("t1_ce",    bus.fb_ce,    1);
        chk("t1_waddr", bus.fb_waddr, 12'h041);
        chk("t1_din",   bus.fb_din,   4'h5);
        cyc();
        chk("t1_we_off", bus.fb_we,    0);
        chk("t1_hold",   bus.fb_waddr, 12'h041);

        // 2: continuous contention alternates 0,1,0,1,...
        do_reset();
        bus.req0_addr = 12'h010; bus.req0_data = 4'h1;
        bus.req1_addr = 12'h820; bus.req1_data = 4'h2;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("t2_r0_%0d", i), bus.req0_ready, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("t2_r1_%0d", i), bus.req1_ready, (i % 2 == 1) ? 1 : 0);
            cyc();
            chk($sformatf("t2_we_%0d", i),    bus.fb_we, 1);
            chk($sformatf("t2_waddr_%0d", i), bus.fb_waddr, (i % 2 == 0) ? 12'h010 : 12'h820);
            chk($sformatf("t2_din_%0d", i),   bus.fb_din,   (i % 2 == 0) ? 4'h1 : 4'h2);
        end
        idle();
        cyc();
        chk("t2_we_off", bus.fb_we, 0);

        // 3: full clear sweep
        bus.clr_start = 1'b1; bus.clr_data = 4'hA;
        cyc();
        bus.clr_start = 1'b0; bus.clr_data = 4'h0;
        chk("t3_busy_rise", bus.clr_busy, 1);
        chk("t3_we0",       bus.fb_we,    0);
        for (int k = 0; k < DEPTH; k++) begin
            cyc();
            chk($sformatf("t3_we_%0d", k),    bus.fb_we,    1);
            chk($sformatf("t3_waddr_%0d", k), bus.fb_waddr, k);
            chk($sformatf("t3_din_%0d", k),   bus.fb_din,   4'hA);
            chk($sformatf("t3_done_%0d", k),  bus.clr_done, (k == DEPTH - 1) ? 1 : 0);
            chk($sformatf("t3_busy_%0d", k),  bus.clr_busy, (k == DEPTH - 1) ? 0 : 1);
        end
        cyc();
        chk("t3_done_off", bus.clr_done, 0);
        chk("t3_we_off",   bus.fb_we,    0);

        // 4: clear wins over a pending port-1 request
        bus.clr_start = 1'b1; bus.clr_data = 4'h3;
        bus.req1_valid = 1'b1; bus.req1_addr = 12'h123; bus.req1_data = 4'h7;
        #1;
        chk("t4_r1_start", bus.req1_ready, 0);
        cyc();
        bus.clr_start = 1'b0;
        bad = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (bus.req1_ready !== 1'b0 || bus.req0_ready !== 1'b0) bad++;
            cyc();
        end
        chk("t4_no_ready_in_clear", bad, 0);
        chk("t4_done", bus.clr_done, 1);
        chk("t4_r1",   bus.req1_ready, 1);
        cyc();
        bus.req1_valid = 1'b0;
        chk("t4_we",    bus.fb_we,    1);
        chk("t4_waddr", bus.fb_waddr, 12'h123);
        chk("t4_din",   bus.fb_din,   4'h7);
        cyc();
        chk("t4_once", bus.fb_we, 0);

        // 5: reset aborts a sweep at address 5
        do_reset();
        bus.clr_start = 1'b1; bus.clr_data = 4'hC;
        cyc();
        bus.clr_start = 1'b0;
        for (int k = 0; k < 6; k++) cyc();
        chk("t5_at5", bus.fb_waddr, 5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t5_we",   bus.fb_we,    0);
        chk("t5_busy", bus.clr_busy, 0);
        chk("t5_done", bus.clr_done, 0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.fb_we !== 1'b0 || bus.clr_done !== 1'b0) bad++;
            cyc();
        end
        chk("t5_quiet", bad, 0);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        chk("t5_rr_r0", bus.req0_ready, 1);
        chk("t5_rr_r1", bus.req1_ready, 0);
        cyc();
        idle();

        // 6: port 1 alone, then contention favours port 0
        do_reset();
        bus.req1_valid = 1'b1; bus.req1_addr = 12'h456; bus.req1_data = 4'h9;
        #1;
        chk("t6_r1_alone", bus.req1_ready, 1);
        chk("t6_r0_alone", bus.req0_ready, 0);
        cyc();
        bus.req0_valid = 1'b1; bus.req0_addr = 12'h789; bus.req0_data = 4'hE;
        chk("t6_waddr1", bus.fb_waddr, 12'h456);
        #1;
        chk("t6_r0_cont", bus.req0_ready, 1);
        chk("t6_r1_cont", bus.req1_ready, 0);
        cyc();
        bus.req0_valid = 1'b0;
        chk("t6_waddr0", bus.fb_waddr, 12'h789);
        chk("t6_din0",   bus.fb_din,   4'hE);
        #1;
        chk("t6_r1_next", bus.req1_ready, 1);
        cyc();
        idle();
        chk("t6_waddr1b", bus.fb_waddr, 12'h456);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
